// File: rtl/mem_ctrl_if.sv
// Request/response and byte-RAM bus between the core-side units and mem_ctrl.
// slave = controller side, master = core/RAM side.
interface mem_ctrl_if #(
    parameter int unsigned OpW = 3
) ();
    logic            ic_en_i;
    logic [31:0]     ic_adr_i;
    logic            ic_en_o;
    logic [31:0]     ic_dat_o;
    logic            dc_en_i;
    logic            dc_rwen_i;
    logic [OpW-1:0]  dc_op_i;
    logic [2:0]      dc_len_i;
    logic [31:0]     dc_adr_i;
    logic [31:0]     dc_dat_i;
    logic            dc_en_o;
    logic [31:0]     dc_dat_o;
    logic [7:0]      mem_din;
    logic [7:0]      mem_dout;
    logic [31:0]     mem_a;
    logic            mem_wr;
    logic            io_buffer_full;
    logic            br_flag;

    modport slave (
        input  ic_en_i, ic_adr_i, dc_en_i, dc_rwen_i, dc_op_i, dc_len_i, dc_adr_i, dc_dat_i,
               mem_din, io_buffer_full, br_flag,
        output ic_en_o, ic_dat_o, dc_en_o, dc_dat_o, mem_dout, mem_a, mem_wr
    );

    modport master (
        output ic_en_i, ic_adr_i, dc_en_i, dc_rwen_i, dc_op_i, dc_len_i, dc_adr_i, dc_dat_i,
               mem_din, io_buffer_full, br_flag,
        input  ic_en_o, ic_dat_o, dc_en_o, dc_dat_o, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating fetches and data loads/stores onto a 1-cycle RAM.
// Define MEM_CTRL_IO_GUARD_EN to stall IO-region (adr[17:16]==2'b11) data requests on io_buffer_full.
module mem_ctrl (
    input  logic      clk,
    input  logic      rst,
    input  logic      en,
    mem_ctrl_if.slave bus
);
    // Op encoding follows RV funct3: bit 2 set selects zero-extension.
    localparam int unsigned OpUnsBit = 2;

    typedef enum logic [1:0] {StIdle, StFetch, StLoad, StStore} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  len_q, len_d;
    logic        uns_q, uns_d;
    logic [31:0] base_q, base_d;
    logic [31:0] buf_q, buf_d;
    logic        dc_done_q, dc_done_d;
    logic [31:0] dc_dat_q, dc_dat_d;
    logic        ic_done_q, ic_done_d;
    logic [31:0] ic_dat_q, ic_dat_d;

    logic        dc_pend_q, dc_pend_d;
    logic        dc_pend_rw_q, dc_pend_rw_d;
    logic        dc_pend_uns_q, dc_pend_uns_d;
    logic [2:0]  dc_pend_len_q, dc_pend_len_d;
    logic [31:0] dc_pend_adr_q, dc_pend_adr_d;
    logic [31:0] dc_pend_dat_q, dc_pend_dat_d;
    logic        ic_pend_q, ic_pend_d;
    logic [31:0] ic_pend_adr_q, ic_pend_adr_d;

    // A live pulse overrides the pending slot, so a request is visible the cycle it arrives.
    logic        dc_req, dc_rw, dc_uns, ic_req, io_hold;
    logic [2:0]  dc_len;
    logic [31:0] dc_adr, dc_wdat, ic_adr;
    logic [1:0]  unused_op_bits;

    assign dc_req  = bus.dc_en_i | dc_pend_q;
    assign dc_rw   = bus.dc_en_i ? bus.dc_rwen_i : dc_pend_rw_q;
    assign dc_uns  = bus.dc_en_i ? bus.dc_op_i[OpUnsBit] : dc_pend_uns_q;
    assign dc_len  = bus.dc_en_i ? bus.dc_len_i : dc_pend_len_q;
    assign dc_adr  = bus.dc_en_i ? bus.dc_adr_i : dc_pend_adr_q;
    assign dc_wdat = bus.dc_en_i ? bus.dc_dat_i : dc_pend_dat_q;
    assign ic_req  = bus.ic_en_i | ic_pend_q;
    assign ic_adr  = bus.ic_en_i ? bus.ic_adr_i : ic_pend_adr_q;
    assign unused_op_bits = bus.dc_op_i[1:0];

`ifdef MEM_CTRL_IO_GUARD_EN
    assign io_hold = dc_req && (dc_adr[17:16] == 2'b11) && bus.io_buffer_full;
`else
    logic unused_io_full;
    assign unused_io_full = bus.io_buffer_full;
    assign io_hold        = 1'b0;
`endif

    function automatic logic [2:0] norm_len(input logic [2:0] l);
        return (l == 3'd1 || l == 3'd2) ? l : 3'd4;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] l,
                                           input logic u);
        case (l)
            3'd1:    return u ? {24'b0, w[7:0]} : {{24{w[7]}}, w[7:0]};
            3'd2:    return u ? {16'b0, w[15:0]} : {{16{w[15]}}, w[15:0]};
            default: return w;
        endcase
    endfunction

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        len_d         = len_q;
        uns_d         = uns_q;
        base_d        = base_q;
        buf_d         = buf_q;
        dc_done_d     = 1'b0;
        dc_dat_d      = '0;
        ic_done_d     = 1'b0;
        ic_dat_d      = '0;
        dc_pend_d     = dc_req;
        dc_pend_rw_d  = dc_rw;
        dc_pend_uns_d = dc_uns;
        dc_pend_len_d = dc_len;
        dc_pend_adr_d = dc_adr;
        dc_pend_dat_d = dc_wdat;
        ic_pend_d     = ic_req;
        ic_pend_adr_d = ic_adr;
        if (en) begin
            if (bus.br_flag) begin
                ic_pend_d = 1'b0;
                if (!dc_rw) dc_pend_d = 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (dc_req && !io_hold && !(bus.br_flag && !dc_rw)) begin
                        dc_pend_d = 1'b0;
                        state_d   = dc_rw ? StStore : StLoad;
                        cnt_d     = '0;
                        len_d     = norm_len(dc_len);
                        uns_d     = dc_uns;
                        base_d    = dc_adr;
                        buf_d     = dc_rw ? dc_wdat : '0;
                    end else if (ic_req && !io_hold && !bus.br_flag) begin
                        ic_pend_d = 1'b0;
                        state_d   = StFetch;
                        cnt_d     = '0;
                        len_d     = 3'd4;
                        uns_d     = 1'b0;
                        base_d    = ic_adr;
                        buf_d     = '0;
                    end
                end
                StLoad, StFetch: begin
                    // Byte k-1 arrives on mem_din while cnt_q == k.
                    case (cnt_q)
                        3'd1:    buf_d[7:0]   = bus.mem_din;
                        3'd2:    buf_d[15:8]  = bus.mem_din;
                        3'd3:    buf_d[23:16] = bus.mem_din;
                        3'd4:    buf_d[31:24] = bus.mem_din;
                        default: ;
                    endcase
                    if (bus.br_flag) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (cnt_q == len_q) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                        if (state_q == StLoad) begin
                            dc_done_d = 1'b1;
                            dc_dat_d  = extend(buf_d, len_q, uns_q);
                        end else begin
                            ic_done_d = 1'b1;
                            ic_dat_d  = buf_d;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                StStore: begin
                    if (cnt_q == len_q - 3'd1) begin
                        state_d   = StIdle;
                        cnt_d     = '0;
                        dc_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        bus.mem_a    = '0;
        bus.mem_wr   = 1'b0;
        bus.mem_dout = '0;
        if (state_q != StIdle && cnt_q < len_q) begin
            bus.mem_a = base_q + {29'b0, cnt_q};
            if (state_q == StStore) begin
                bus.mem_wr = 1'b1;
                case (cnt_q[1:0])
                    2'd0: bus.mem_dout = buf_q[7:0];
                    2'd1: bus.mem_dout = buf_q[15:8];
                    2'd2: bus.mem_dout = buf_q[23:16];
                    2'd3: bus.mem_dout = buf_q[31:24];
                endcase
            end
        end
    end

    assign bus.dc_en_o  = dc_done_q;
    assign bus.dc_dat_o = dc_dat_q;
    assign bus.ic_en_o  = ic_done_q;
    assign bus.ic_dat_o = ic_dat_q;

    // Pending slots keep capturing pulses while en is low; everything else freezes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            len_q         <= '0;
            uns_q         <= 1'b0;
            base_q        <= '0;
            buf_q         <= '0;
            dc_done_q     <= 1'b0;
            dc_dat_q      <= '0;
            ic_done_q     <= 1'b0;
            ic_dat_q      <= '0;
            dc_pend_q     <= 1'b0;
            dc_pend_rw_q  <= 1'b0;
            dc_pend_uns_q <= 1'b0;
            dc_pend_len_q <= '0;
            dc_pend_adr_q <= '0;
            dc_pend_dat_q <= '0;
            ic_pend_q     <= 1'b0;
            ic_pend_adr_q <= '0;
        end else begin
            dc_pend_q     <= dc_pend_d;
            dc_pend_rw_q  <= dc_pend_rw_d;
            dc_pend_uns_q <= dc_pend_uns_d;
            dc_pend_len_q <= dc_pend_len_d;
            dc_pend_adr_q <= dc_pend_adr_d;
            dc_pend_dat_q <= dc_pend_dat_d;
            ic_pend_q     <= ic_pend_d;
            ic_pend_adr_q <= ic_pend_adr_d;
            if (en) begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                len_q     <= len_d;
                uns_q     <= uns_d;
                base_q    <= base_d;
                buf_q     <= buf_d;
                dc_done_q <= dc_done_d;
                dc_dat_q  <= dc_dat_d;
                ic_done_q <= ic_done_d;
                ic_dat_q  <= ic_dat_d;
            end
        end
    end
endmodule
